reg_stage_skid: RTL and testbench

REG_STAGE_SKID -- requirements
Module: reg_stage_skid

---
 rtl/reg_stage_skid.sv | 84 ++++++++
 tb/tb_reg_stage_skid.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/reg_stage_skid.sv
// rtl/reg_stage_skid.sv - two-entry register write-back stage with registered-ready skid buffer
module reg_stage_skid #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 5,
    parameter bit ZERO_SUPPRESS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_waddr,
    input  logic              in_we,
    input  logic [DATA_W-1:0] in_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_waddr,
    output logic              out_we,
    output logic [DATA_W-1:0] out_wdata,
    output logic [1:0]        count
);

    logic              main_valid, skid_valid;
    logic [ADDR_W-1:0] main_waddr, skid_waddr;
    logic              main_we, skid_we;
    logic [DATA_W-1:0] main_wdata, skid_wdata;

    logic accept, pop, cap_we;

    // in_ready depends only on the skid register, never on out_ready
    assign in_ready = !skid_valid;
    assign accept   = in_valid && !skid_valid;
    assign pop      = main_valid && out_ready;
    assign cap_we   = in_we && !(ZERO_SUPPRESS && (in_waddr == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_waddr <= '0;
            main_we    <= 1'b0;
            main_wdata <= '0;
            skid_waddr <= '0;
            skid_we    <= 1'b0;
            skid_wdata <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid) begin
            if (accept) begin
                main_valid <= 1'b1;
                main_waddr <= in_waddr;
                main_we    <= cap_we;
                main_wdata <= in_wdata;
            end
        end else if (!skid_valid) begin
            if (accept && pop) begin
                main_waddr <= in_waddr;
                main_we    <= cap_we;
                main_wdata <= in_wdata;
            end else if (accept) begin
                skid_valid <= 1'b1;
                skid_waddr <= in_waddr;
                skid_we    <= cap_we;
                skid_wdata <= in_wdata;
            end else if (pop) begin
                main_valid <= 1'b0;
            end
        end else if (pop) begin
            // full: skid promotes to head; input is blocked this cycle
            skid_valid <= 1'b0;
            main_waddr <= skid_waddr;
            main_we    <= skid_we;
            main_wdata <= skid_wdata;
        end
    end

    assign out_valid = main_valid;
    assign out_waddr = main_waddr;
    assign out_we    = main_valid && main_we;
    assign out_wdata = main_wdata;
    assign count     = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_reg_stage_skid.sv
// tb/tb_reg_stage_skid.sv - scoreboard bench for reg_stage_skid
module tb_reg_stage_skid;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_we, out_ready;
    logic [4:0]  in_waddr;
    logic [31:0] in_wdata;
    logic        in_ready, out_valid, out_we;
    logic [4:0]  out_waddr;
    logic [31:0] out_wdata;
    logic [1:0]  count;
    logic        z_in_ready, z_out_valid, z_out_we;
    logic [4:0]  z_out_waddr;
    logic [31:0] z_out_wdata;
    logic [1:0]  z_count;

    always #5 clk = ~clk;

    reg_stage_skid #(.DATA_W(32), .ADDR_W(5), .ZERO_SUPPRESS(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_waddr(in_waddr),
        .in_we(in_we), .in_wdata(in_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_waddr(out_waddr),
        .out_we(out_we), .out_wdata(out_wdata), .count(count)
    );

    reg_stage_skid #(.DATA_W(32), .ADDR_W(5), .ZERO_SUPPRESS(1'b0)) dut_nz (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(z_in_ready), .in_waddr(in_waddr),
        .in_we(in_we), .in_wdata(in_wdata),
        .out_valid(z_out_valid), .out_ready(out_ready), .out_waddr(z_out_waddr),
        .out_we(z_out_we), .out_wdata(z_out_wdata), .count(z_count)
    );

    typedef struct {
        logic [4:0]  waddr;
        logic        we;
        logic        raw_we;
        logic [31:0] wdata;
    } ent_t;

    ent_t q[$];
    ent_t last_head;
    int   total = 0;
    int   bad   = 0;
    int   accepted = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic we,
                         input logic [31:0] d, input logic ordy, input logic fl);
        in_valid  = v;
        in_waddr  = a;
        in_we     = we;
        in_wdata  = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    // compare outputs against the model, then advance the model across one edge
    task automatic cyc();
        int n;
        bit pop_e, acc_e;
        ent_t e;
        #1;
        n = q.size();
        chk("count", 64'(count), 64'(n));
        chk("in_ready", 64'(in_ready), 64'(n < 2));
        chk("out_valid", 64'(out_valid), 64'(n > 0));
        if (n > 0) begin
            chk("out_waddr", 64'(out_waddr), 64'(q[0].waddr));
            chk("out_we", 64'(out_we), 64'(q[0].we));
            chk("out_wdata", 64'(out_wdata), 64'(q[0].wdata));
            chk("nz_out_we", 64'(z_out_we), 64'(q[0].raw_we));
        end else begin
            chk("idle_out_we", 64'(out_we), 64'(0));
            chk("idle_out_waddr", 64'(out_waddr), 64'(last_head.waddr));
            chk("idle_out_wdata", 64'(out_wdata), 64'(last_head.wdata));
            chk("nz_idle_out_we", 64'(z_out_we), 64'(0));
        end
        if (rst) begin
            q.delete();
            last_head = '{5'd0, 1'b0, 1'b0, 32'd0};
        end else if (flush) begin
            q.delete();
        end else begin
            pop_e = (n > 0) && out_ready;
            acc_e = in_valid && (n < 2);
            if (pop_e) void'(q.pop_front());
            if (acc_e) begin
                e.waddr  = in_waddr;
                e.raw_we = in_we;
                e.we     = in_we && (in_waddr != 5'd0);
                e.wdata  = in_wdata;
                q.push_back(e);
                accepted++;
            end
        end
        if (q.size() > 0) last_head = q[0];
        @(posedge clk);
        #1;
    endtask

    initial begin
        last_head = '{5'd0, 1'b0, 1'b0, 32'd0};
        drive(0, 5'd0, 0, 32'd0, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        cyc();
        rst = 1'b0;
        cyc();

        // pass-through
        drive(1, 5'd3, 1, 32'hDEADBEEF, 1, 0); cyc();
        drive(0, 5'd0, 0, 32'd0, 1, 0);         cyc(); cyc();

        // backpressure, offer while full, then drain
        drive(1, 5'd1, 1, 32'hA, 0, 0); cyc();
        drive(1, 5'd2, 1, 32'hB, 0, 0); cyc();
        drive(1, 5'd7, 1, 32'hC, 0, 0); cyc();
        drive(0, 5'd0, 0, 32'd0, 1, 0); cyc(); cyc(); cyc();

        // zero-address suppression
        drive(1, 5'd0, 1, 32'h55, 0, 0); cyc();
        drive(0, 5'd0, 0, 32'd0, 1, 0);  cyc(); cyc();

        // flush while full with concurrent accept/pop offered
        drive(1, 5'd4, 1, 32'h44, 0, 0); cyc();
        drive(1, 5'd5, 1, 32'h55, 0, 0); cyc();
        drive(1, 5'd9, 1, 32'h99, 1, 1); cyc();
        drive(0, 5'd0, 0, 32'd0, 1, 0);  cyc(); cyc();

        // reset mid-stream, then one-cycle latency afterwards
        drive(1, 5'd6, 1, 32'h66, 0, 0); cyc();
        drive(1, 5'd8, 1, 32'h88, 0, 0); cyc();
        drive(1, 5'd10, 1, 32'hAA, 1, 0);
        rst = 1'b1; cyc();
        rst = 1'b0;
        drive(1, 5'd11, 1, 32'hBB, 1, 0); cyc();
        drive(0, 5'd0, 0, 32'd0, 1, 0);   cyc(); cyc();

        // random stream of 1000 entries, then drain
        accepted = 0;
        for (int c = 0; c < 20000 && accepted < 1000; c++) begin
            drive($urandom_range(0, 1), 5'($urandom), 1'($urandom), $urandom,
                  $urandom_range(0, 1), 0);
            cyc();
        end
        chk("random_accepted", 64'(accepted >= 1000), 64'(1));
        for (int c = 0; c < 10; c++) begin
            drive(0, 5'd0, 0, 32'd0, 1, 0);
            cyc();
        end
        chk("drained", 64'(q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
